// File: rtl/ex_stage_if.sv
// Execute-stage bundle: ID/EX operands and control in, EX/MEM register and stall out.
// ovf_exc exists only when EX_OVERFLOW_TRAP_EN is defined.
interface ex_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic [2:0]       ex_alusel;
    logic [4:0]       ex_aluop;
    logic [WIDTH-1:0] ex_srcLeft;
    logic [WIDTH-1:0] ex_srcRight;
    logic [3:0]       ex_memop;
    logic [4:0]       ex_dest;
    logic             ex_writeEnable;
    logic             stall_req;
    logic [WIDTH-1:0] mem_result;
    logic [4:0]       mem_dest;
    logic [3:0]       mem_memop;
    logic             mem_writeEnable;
`ifdef EX_OVERFLOW_TRAP_EN
    logic             ovf_exc;
`endif

    modport master (
`ifdef EX_OVERFLOW_TRAP_EN
        input  ovf_exc,
`endif
        output flush, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_memop, ex_dest,
               ex_writeEnable,
        input  stall_req, mem_result, mem_dest, mem_memop, mem_writeEnable
    );

    modport slave (
`ifdef EX_OVERFLOW_TRAP_EN
        output ovf_exc,
`endif
        input  flush, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight, ex_memop, ex_dest,
               ex_writeEnable,
        output stall_req, mem_result, mem_dest, mem_memop, mem_writeEnable
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register: single-cycle ALU plus 32-step restoring divider.
// Define EX_OVERFLOW_TRAP_EN to suppress writeback on signed ADD/SUB overflow and drive ovf_exc.
module ex_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIV_CNT_W = 5
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    localparam logic [2:0] SelSpecial = 3'd0;
    localparam logic [2:0] SelLogic   = 3'd1;
    localparam logic [2:0] SelArith   = 3'd2;
    localparam logic [2:0] SelShift   = 3'd3;
    localparam logic [2:0] SelDiv     = 3'd4;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic                 neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, sel_rem_q, sel_rem_d;
    logic [4:0]           div_dest_q, div_dest_d;
    logic [3:0]           div_memop_q, div_memop_d;
    logic                 div_we_q, div_we_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [4:0]           dest_q, dest_d;
    logic [3:0]           memop_q, memop_d;
    logic                 we_q, we_d;
    logic                 stall;

    logic [WIDTH-1:0] a, b, sum, diff, alu_res, left_abs, right_abs, quot_fix, rem_fix;
    logic [WIDTH:0]   shifted, trial;
    logic [4:0]       shamt;
    logic             is_div, div_signed, div_zero;

    assign a          = bus.ex_srcLeft;
    assign b          = bus.ex_srcRight;
    assign sum        = a + b;
    assign diff       = a - b;
    assign shamt      = b[4:0];
    assign is_div     = (bus.ex_alusel == SelDiv) && (bus.ex_aluop < 5'd4);
    assign div_signed = ~bus.ex_aluop[1];
    assign div_zero   = (b == '0);
    assign left_abs   = (div_signed && a[WIDTH-1]) ? -a : a;
    assign right_abs  = (div_signed && b[WIDTH-1]) ? -b : b;

    // Restoring step: borrow out of the trial subtract decides the quotient bit.
    assign shifted  = {rem_q, quot_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign quot_fix = neg_quot_q ? -quot_q : quot_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        alu_res = '0;
        case (bus.ex_alusel)
            SelLogic: begin
                case (bus.ex_aluop)
                    5'd0:    alu_res = a & b;
                    5'd1:    alu_res = a | b;
                    5'd2:    alu_res = a ^ b;
                    5'd3:    alu_res = ~(a | b);
                    default: alu_res = '0;
                endcase
            end
            SelArith: begin
                case (bus.ex_aluop)
                    5'd0:    alu_res = sum;
                    5'd1:    alu_res = diff;
                    5'd2:    alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                    5'd3:    alu_res = {{(WIDTH-1){1'b0}}, a < b};
                    default: alu_res = '0;
                endcase
            end
            SelShift: begin
                case (bus.ex_aluop)
                    5'd0:    alu_res = a << shamt;
                    5'd1:    alu_res = a >> shamt;
                    5'd2:    alu_res = $unsigned($signed(a) >>> shamt);
                    default: alu_res = '0;
                endcase
            end
            // Only the divide-by-zero case completes in one cycle.
            SelDiv:  alu_res = (is_div && div_zero) ? (bus.ex_aluop[0] ? a : '1) : '0;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic ovf_q, ovf_d, arith_ovf;
    always_comb begin
        arith_ovf = 1'b0;
        if (bus.ex_alusel == SelArith && bus.ex_aluop == 5'd0) begin
            arith_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (bus.ex_alusel == SelArith && bus.ex_aluop == 5'd1) begin
            arith_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
    end
    assign bus.ovf_exc = ovf_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dvsr_d      = dvsr_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        sel_rem_d   = sel_rem_q;
        div_dest_d  = div_dest_q;
        div_memop_d = div_memop_q;
        div_we_d    = div_we_q;
        stall       = 1'b0;
        res_d       = alu_res;
        dest_d      = bus.ex_dest;
        memop_d     = bus.ex_memop;
        we_d        = bus.ex_writeEnable;
`ifdef EX_OVERFLOW_TRAP_EN
        ovf_d       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (is_div && !div_zero) begin
                    stall       = 1'b1;
                    state_d     = StBusy;
                    cnt_d       = '0;
                    rem_d       = '0;
                    quot_d      = left_abs;
                    dvsr_d      = right_abs;
                    neg_quot_d  = div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d   = div_signed && a[WIDTH-1];
                    sel_rem_d   = bus.ex_aluop[0];
                    div_dest_d  = bus.ex_dest;
                    div_memop_d = bus.ex_memop;
                    div_we_d    = bus.ex_writeEnable;
                    {res_d, dest_d, memop_d, we_d} = '0;
                end else if (bus.ex_alusel == SelSpecial) begin
                    {res_d, dest_d, memop_d, we_d} = '0;
                end else begin
`ifdef EX_OVERFLOW_TRAP_EN
                    if (arith_ovf) begin
                        we_d    = 1'b0;
                        memop_d = '0;
                        ovf_d   = 1'b1;
                    end
`endif
                end
            end
            StBusy: begin
                stall  = 1'b1;
                rem_d  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == {DIV_CNT_W{1'b1}}) state_d = StDone;
                {res_d, dest_d, memop_d, we_d} = '0;
            end
            StDone: begin
                state_d = StIdle;
                res_d   = sel_rem_q ? rem_fix : quot_fix;
                dest_d  = div_dest_q;
                memop_d = div_memop_q;
                we_d    = div_we_q;
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d = StIdle;
            stall   = 1'b0;
            {res_d, dest_d, memop_d, we_d} = '0;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    assign bus.stall_req       = stall && !rst;
    assign bus.mem_result      = res_q;
    assign bus.mem_dest        = dest_q;
    assign bus.mem_memop       = memop_q;
    assign bus.mem_writeEnable = we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            sel_rem_q   <= 1'b0;
            div_dest_q  <= '0;
            div_memop_q <= '0;
            div_we_q    <= 1'b0;
            res_q       <= '0;
            dest_q      <= '0;
            memop_q     <= '0;
            we_q        <= 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            sel_rem_q   <= sel_rem_d;
            div_dest_q  <= div_dest_d;
            div_memop_q <= div_memop_d;
            div_we_q    <= div_we_d;
            res_q       <= res_d;
            dest_q      <= dest_d;
            memop_q     <= memop_d;
            we_q        <= we_d;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_q       <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations queued at issue time, popped by a negedge monitor.
// Honours EX_OVERFLOW_TRAP_EN in its reference model.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_if #(.WIDTH(32)) bus ();
    ex_stage #(.WIDTH(32), .DIV_CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int unsigned due;
        logic [31:0] res;
        logic [4:0]  dest;
        logic [3:0]  memop;
        logic        we;
        logic        ovf;
    } exp_t;

    exp_t        out_q[$];
    logic        stall_q[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall is checked against the inputs of the current cycle, mem_* against the
    // entry issued in the previous cycle.
    always @(negedge clk) begin
        logic act_ovf;
        exp_t e;
`ifdef EX_OVERFLOW_TRAP_EN
        act_ovf = bus.ovf_exc;
`else
        act_ovf = 1'b0;
`endif
        if (stall_q.size() > 0) begin
            logic s;
            s = stall_q.pop_front();
            total++;
            if (bus.stall_req === s) passed++;
            else $display("FAIL stall@%0d: got %b want %b", cyc, bus.stall_req, s);
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            e = out_q.pop_front();
            total++;
            if (e.due == cyc && bus.mem_result === e.res && bus.mem_dest === e.dest &&
                bus.mem_memop === e.memop && bus.mem_writeEnable === e.we && act_ovf === e.ovf)
                passed++;
            else
                $display("FAIL out@%0d: got res=%h dest=%0d memop=%h we=%b ovf=%b want res=%h dest=%0d memop=%h we=%b ovf=%b",
                         cyc, bus.mem_result, bus.mem_dest, bus.mem_memop, bus.mem_writeEnable,
                         act_ovf, e.res, e.dest, e.memop, e.we, e.ovf);
        end
    end

    function automatic exp_t bubble();
        exp_t e;
        e.due = 0; e.res = '0; e.dest = '0; e.memop = '0; e.we = 1'b0; e.ovf = 1'b0;
        return e;
    endfunction

    // Divide by arithmetic on 64-bit integers; truncation toward zero gives the sign rules.
    function automatic logic [31:0] div_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1] == 1'b0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return op[0] ? r[31:0] : q[31:0];
    endfunction

    function automatic exp_t model(logic [2:0] sel, logic [4:0] op, logic [31:0] a,
                                   logic [31:0] b, logic [4:0] dest, logic we, logic [3:0] memop);
        exp_t   e;
        longint s;
        e = bubble();
        if (sel == 3'd0) return e;
        e.dest = dest; e.we = we; e.memop = memop;
        case ({sel, op})
            {3'd1, 5'd0}: e.res = a & b;
            {3'd1, 5'd1}: e.res = a | b;
            {3'd1, 5'd2}: e.res = a ^ b;
            {3'd1, 5'd3}: e.res = ~(a | b);
            {3'd2, 5'd0}: e.res = a + b;
            {3'd2, 5'd1}: e.res = a - b;
            {3'd2, 5'd2}: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            {3'd2, 5'd3}: e.res = (a < b) ? 32'd1 : 32'd0;
            {3'd3, 5'd0}: e.res = a << b[4:0];
            {3'd3, 5'd1}: e.res = a >> b[4:0];
            {3'd3, 5'd2}: e.res = $unsigned($signed(a) >>> b[4:0]);
            default:      e.res = (sel == 3'd4 && op < 4) ? div_model(op, a, b) : 32'd0;
        endcase
`ifdef EX_OVERFLOW_TRAP_EN
        if (sel == 3'd2 && (op == 5'd0 || op == 5'd1)) begin
            s = (op == 5'd0) ? longint'($signed(a)) + longint'($signed(b))
                             : longint'($signed(a)) - longint'($signed(b));
            if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
                e.we = 1'b0; e.memop = '0; e.ovf = 1'b1;
            end
        end
`else
        s = 0;
`endif
        return e;
    endfunction

    // Presents one op (held across the whole divide); abort_at picks the cycle that sees
    // flush (use_rst=0) or rst (use_rst=1), -1 for none.
    task automatic issue(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest, input logic we,
                         input logic [3:0] memop, input int abort_at, input bit use_rst);
        bit   long_op;
        int   n;
        exp_t e;
        long_op = (sel == 3'd4) && (op < 4) && (b != 0);
        n = long_op ? 34 : 1;
        bus.ex_alusel = sel; bus.ex_aluop = op; bus.ex_srcLeft = a; bus.ex_srcRight = b;
        bus.ex_dest = dest; bus.ex_writeEnable = we; bus.ex_memop = memop;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
                stall_q.push_back(1'b0);
                e = bubble();
                e.due = cyc + 1;
                out_q.push_back(e);
                @(posedge clk); #1;
                rst = 1'b0; bus.flush = 1'b0;
                return;
            end
            if (long_op) begin
                stall_q.push_back(i <= 32);
                if (i == 33) begin
                    e = model(sel, op, a, b, dest, we, memop);
                end else begin
                    e = bubble();
                end
            end else begin
                stall_q.push_back(1'b0);
                e = model(sel, op, a, b, dest, we, memop);
            end
            e.due = cyc + 1;
            out_q.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.flush = 1'b0; bus.ex_alusel = '0; bus.ex_aluop = '0; bus.ex_srcLeft = '0;
        bus.ex_srcRight = '0; bus.ex_memop = '0; bus.ex_dest = '0; bus.ex_writeEnable = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) issue(3'd4, 5'd0, 32'd9, 32'd2, 5'd1, 1'b1, 4'd0, 0, 1'b1);

        issue(3'd1, 5'd1, 32'h0F0F_0000, 32'h0000_F0F0, 5'd3, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd2, 5'd2, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd2, 5'd3, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd3, 5'd2, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd0, 5'd0, 32'h1234, 32'h5678, 5'd6, 1'b1, 4'd3, -1, 1'b0);
        issue(3'd4, 5'd0, -32'sd7, 32'd2, 5'd7, 1'b1, 4'd2, -1, 1'b0);
        issue(3'd4, 5'd1, -32'sd7, 32'd2, 5'd8, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd2, 32'd100, 32'd0, 5'd10, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd3, 32'd100, 32'd0, 5'd10, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd2, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd0, 32'd1000, 32'd7, 5'd12, 1'b1, 4'd0, 11, 1'b0);
        issue(3'd2, 5'd0, 32'd2, 32'd3, 5'd13, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd4, 5'd0, 32'd1000, 32'd7, 5'd12, 1'b1, 4'd0, 11, 1'b1);
        issue(3'd2, 5'd0, 32'd2, 32'd3, 5'd13, 1'b1, 4'd0, -1, 1'b0);
        issue(3'd2, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd14, 1'b1, 4'd1, -1, 1'b0);
        issue(3'd2, 5'd1, 32'h8000_0000, 32'd1, 5'd15, 1'b1, 4'd1, -1, 1'b0);
        issue(3'd1, 5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1, 4'd5, -1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [2:0]  sel;
            logic [4:0]  op;
            logic [31:0] a, b;
            int          abort_at;
            bit          use_rst;
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) sel = 3'd4;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 40));
                1: b = 32'd0;
                2: a = 32'($urandom_range(0, 300));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            abort_at = -1;
            use_rst = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                abort_at = $urandom_range(0, 33);
                use_rst = ($urandom_range(0, 3) == 0);
            end
            issue(sel, op, a, b, 5'($urandom), 1'($urandom), 4'($urandom), abort_at, use_rst);
        end

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_q.size() == 0 && stall_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d/%0d pending entries want 0/0",
                      out_q.size(), stall_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
